mult_sequencer: RTL and testbench
=================================

# mult_sequencer

Sequencer for the 8-bit shift-add multiplier datapath (A/X/B registers, 9-bit add/subtract unit). It turns the Run and ClearA_LoadB push-buttons into a one-shot, counter-driven sequence: clear, then WIDTH add/shift pairs, with subtract on the final step. It sits between the debounced push-button inputs and the datapath register enables, and replaces per-bit unrolled states with a bit counter.

## Interface
- WIDTH, 8: multiplier operand width; number of add/shift pairs per run (≥2).
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset.
- Run  in  1  active-low start button, synchronised upstream.
- ClearA_LoadB  in  1  active-low clear-A/load-B button, synchronised upstream.
- M  in  1  current multiplier LSB (B[0]) from the datapath.
- ClrA_LdB  out  1  datapath: clear A and X, load B from switches.
- ClrAX  out  1  datapath: clear A and X only (start of run).
- Add_En  out  1  datapath: load A and X from the adder result.
- Sub_En  out  1  adder function select: 1 = subtract, 0 = add.
- Shift_En  out  1  datapath: arithmetic-shift X:A:B right by one.
- Busy  out  1  high while a multiply is in progress.
- Done  out  1  high while the result is held after a run.
- Bit_Cnt  out  $clog2(WIDTH)  index of the current add/shift pair.

## Operation
- States: IDLE, CLEAR, ADD, SHIFT, DONE. Register `armed` is set whenever Run is high and cleared on start.
- IDLE:
  - If ClearA_LoadB is low, assert ClrA_LdB and stay in IDLE. Load has priority over Run.
  - Otherwise, if Run is low and `armed` is set, go to CLEAR.
- CLEAR: assert ClrAX, set Bit_Cnt to 0, go to ADD.
- ADD:
  - Add_En = M (combinational).
  - Sub_En = 1 when Bit_Cnt == WIDTH-1, otherwise 0. Sub_En is 0 in all other states.
  - Go to SHIFT.
- SHIFT: assert Shift_En.
  - If Bit_Cnt == WIDTH-1, go to DONE.
  - Otherwise increment Bit_Cnt and go to ADD.
- DONE:
  - Hold until Run is high, then go to IDLE. `armed` is set the same cycle.
  - ClearA_LoadB low in DONE asserts ClrA_LdB and does not leave DONE.
- ClearA_LoadB is ignored in CLEAR, ADD and SHIFT. Run is ignored outside IDLE, except for the DONE exit.
- Busy = CLEAR | ADD | SHIFT. Done = DONE.
- At most one of ClrA_LdB, ClrAX, Add_En and Shift_En is high in any cycle.
- Bit_Cnt never wraps within a run. It holds WIDTH-1 in DONE and resets to 0 only in CLEAR or on Reset.

## Timing
- Reset low at an edge: next state IDLE, Bit_Cnt 0, `armed` 0, all outputs 0. This applies from any state, including mid-run.
- After Reset, Run must be seen high at least once before a start is accepted.
- All outputs decode combinationally from registered state. Add_En is Mealy on M.
- Cycle numbering: cycle 0 is the edge at which IDLE samples Run low with `armed` set.
  - Cycle 1: CLEAR.
  - Cycles 2k+2: ADD for pair k.
  - Cycles 2k+3: SHIFT for pair k, k = 0..WIDTH-1.
  - Cycle 2·WIDTH+2: first DONE cycle (18 for WIDTH=8).
- Exit from DONE: the edge that samples Run high enters IDLE. A new start needs a later edge that samples Run low.
- Run held low continuously produces exactly one multiply.

## Test plan
- Reset: Reset low for 2 cycles from an arbitrary state → all outputs 0 and Bit_Cnt 0. Run low with Run never high after reset → stays in IDLE.
- Full run, WIDTH=8: the bench models B = 8'b1000_0001 and shifts it on Shift_En, driving M from it.
  - Add_En is high at cycles 2 and 16 only, with Sub_En = 1 only at cycle 16.
  - Shift_En is high at cycles 3, 5, …, 17 (8 pulses).
  - Done rises at cycle 18; Busy is high for cycles 1–17.
- One-shot: Run held low 40 cycles → a single sequence, Done held from cycle 18. Release Run → IDLE on the next edge; re-press → new CLEAR.
- Button conflicts:
  - ClearA_LoadB low during cycles 5–9 → ClrA_LdB stays 0 and the sequence is unchanged.
  - Run and ClearA_LoadB low together in IDLE → ClrA_LdB high and no start.
- Reset mid-run: Reset low at cycle 9 → IDLE at that edge, Shift_En/Add_En 0, Bit_Cnt 0. Run must be released and re-pressed to restart.
- M all zeros → Add_En never asserts, and Shift_En/Done timing is identical to the full-run case.

Source files
------------

// File: rtl/mult_sequencer.sv
// Control sequencer for the 8-bit shift-add multiplier datapath.
// Turns the Run / ClearA_LoadB buttons into one clear plus WIDTH add/shift pairs per press.
module mult_sequencer #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic             M,
    output logic             ClrA_LdB,
    output logic             ClrAX,
    output logic             Add_En,
    output logic             Sub_En,
    output logic             Shift_En,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Bit_Cnt
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ADD,
        SHIFT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(WIDTH - 1);

    state_t           state;
    logic             armed;
    logic [CNT_W-1:0] bit_cnt;
    logic             last_pair;
    logic             start;

    assign last_pair = (bit_cnt == LAST_PAIR);
    // Load button wins over Run, and a start needs Run to have been seen released first.
    assign start     = (state == IDLE) && ClearA_LoadB && !Run && armed;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            armed   <= 1'b0;
        end else begin
            if (start) begin
                armed <= 1'b0;
            end else if (Run) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    bit_cnt <= '0;
                    state   <= ADD;
                end
                ADD: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (last_pair) begin
                        state <= DONE;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        state   <= ADD;
                    end
                end
                DONE: begin
                    if (Run && ClearA_LoadB) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Add_En follows the live multiplier bit; the last pair subtracts (two's-complement sign weight).
    assign ClrA_LdB = ((state == IDLE) || (state == DONE)) && !ClearA_LoadB;
    assign ClrAX    = (state == CLEAR);
    assign Add_En   = (state == ADD) && M;
    assign Sub_En   = (state == ADD) && last_pair;
    assign Shift_En = (state == SHIFT);
    assign Busy     = (state == CLEAR) || (state == ADD) || (state == SHIFT);
    assign Done     = (state == DONE);
    assign Bit_Cnt  = bit_cnt;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: behavioural run model plus literal timing checks.
module tb_mult_sequencer;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH);

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Run;
    logic          ClearA_LoadB;
    logic          M;
    logic          ClrA_LdB;
    logic          ClrAX;
    logic          Add_En;
    logic          Sub_En;
    logic          Shift_En;
    logic          Busy;
    logic          Done;
    logic [CW-1:0] Bit_Cnt;

    mult_sequencer #(.WIDTH(WIDTH)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .M            (M),
        .ClrA_LdB     (ClrA_LdB),
        .ClrAX        (ClrAX),
        .Add_En       (Add_En),
        .Sub_En       (Sub_En),
        .Shift_En     (Shift_En),
        .Busy         (Busy),
        .Done         (Done),
        .Bit_Cnt      (Bit_Cnt)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 running (step 1 = clear, then add/shift pairs), 2 done.
    int             mMode  = 0;
    int             mStep  = 0;
    int             mCnt   = 0;
    bit             mArmed = 1'b0;
    bit             checkEn = 1'b0;
    logic [WIDTH-1:0] bModel   = '0;
    logic [WIDTH-1:0] switches = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void modelOutputs(output bit eClrLd, output bit eClrAX, output bit eAdd,
                                         output bit eSub, output bit eShift, output bit eBusy,
                                         output bit eDone, output int eCnt);
        int k;
        eClrLd = 0; eClrAX = 0; eAdd = 0; eSub = 0; eShift = 0; eBusy = 0; eDone = 0;
        eCnt = mCnt;
        if (mMode == 0) begin
            eClrLd = !ClearA_LoadB;
        end else if (mMode == 1) begin
            eBusy = 1;
            if (mStep == 1) begin
                eClrAX = 1;
            end else if (mStep % 2 == 0) begin
                k    = (mStep - 2) / 2;
                eAdd = M;
                eSub = (k == WIDTH - 1);
                eCnt = k;
            end else begin
                eShift = 1;
                eCnt   = (mStep - 3) / 2;
            end
        end else begin
            eDone  = 1;
            eClrLd = !ClearA_LoadB;
            eCnt   = WIDTH - 1;
        end
    endfunction

    always @(negedge Clk) begin
        bit eClrLd, eClrAX, eAdd, eSub, eShift, eBusy, eDone;
        int eCnt;
        if (checkEn) begin
            modelOutputs(eClrLd, eClrAX, eAdd, eSub, eShift, eBusy, eDone, eCnt);
            checkOutput("ClrA_LdB", 32'(ClrA_LdB), 32'(eClrLd));
            checkOutput("ClrAX", 32'(ClrAX), 32'(eClrAX));
            checkOutput("Add_En", 32'(Add_En), 32'(eAdd));
            checkOutput("Sub_En", 32'(Sub_En), 32'(eSub));
            checkOutput("Shift_En", 32'(Shift_En), 32'(eShift));
            checkOutput("Busy", 32'(Busy), 32'(eBusy));
            checkOutput("Done", 32'(Done), 32'(eDone));
            if (!(mMode == 1 && mStep == 1)) begin
                checkOutput("Bit_Cnt", 32'(Bit_Cnt), 32'(eCnt));
            end
        end
    end

    task automatic applyStimulus(input bit r, input bit run, input bit clb);
        Reset        = r;
        Run          = run;
        ClearA_LoadB = clb;
    endtask

    // One clock edge: advance the model and the datapath B register with the sampled inputs.
    task automatic tick();
        bit eClrLd, eClrAX, eAdd, eSub, eShift, eBusy, eDone;
        int eCnt;
        bit start;
        modelOutputs(eClrLd, eClrAX, eAdd, eSub, eShift, eBusy, eDone, eCnt);
        @(posedge Clk);
        #1;
        if (eClrLd) bModel = switches;
        else if (eShift) bModel = bModel >> 1;
        if (!Reset) begin
            mMode = 0; mStep = 0; mCnt = 0; mArmed = 0;
            checkEn = 1'b1;
        end else begin
            start = (mMode == 0) && ClearA_LoadB && !Run && mArmed;
            case (mMode)
                0: if (start) begin mMode = 1; mStep = 1; end
                1: if (mStep == 2 * WIDTH + 1) begin mMode = 2; mCnt = WIDTH - 1; end
                   else mStep++;
                default: if (Run && ClearA_LoadB) mMode = 0;
            endcase
            if (start) mArmed = 0;
            else if (Run) mArmed = 1;
        end
        M = bModel[0];
    endtask

    // Starts a run with Run held low for 41 edges and pins the cycle timing with literals.
    task automatic runAndCheckTiming(input bit withAdds);
        int shifts = 0;
        applyStimulus(1, 0, 1);
        tick();
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (c <= 20) begin
                checkOutput($sformatf("lit_add_c%0d", c), 32'(Add_En), 32'(withAdds && (c == 2 || c == 16)));
                checkOutput($sformatf("lit_sub_c%0d", c), 32'(Sub_En), 32'(c == 16));
                checkOutput($sformatf("lit_shift_c%0d", c), 32'(Shift_En), 32'(c >= 3 && c <= 17 && c % 2 == 1));
                checkOutput($sformatf("lit_busy_c%0d", c), 32'(Busy), 32'(c <= 17));
                checkOutput($sformatf("lit_done_c%0d", c), 32'(Done), 32'(c >= 18));
            end
            if (Shift_En) shifts++;
            applyStimulus(1, 0, 1);
            tick();
        end
        #1;
        checkOutput("lit_shift_count", 32'(shifts), 32'(8));
        checkOutput("lit_done_held", 32'(Done), 32'(1));
        checkOutput("lit_cnt_done", 32'(Bit_Cnt), 32'(7));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout at %0t", $time);
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        Reset = 1'b0; Run = 1'b0; ClearA_LoadB = 1'b1; M = 1'b0;

        // Reset, then Run low that was never seen high must not start.
        applyStimulus(0, 0, 1);
        tick();
        tick();
        #1;
        checkOutput("lit_rst_busy", 32'(Busy), 32'(0));
        checkOutput("lit_rst_done", 32'(Done), 32'(0));
        checkOutput("lit_rst_cnt", 32'(Bit_Cnt), 32'(0));
        checkOutput("lit_rst_clrld", 32'(ClrA_LdB), 32'(0));
        applyStimulus(1, 0, 1);
        repeat (5) tick();
        #1;
        checkOutput("lit_no_arm_busy", 32'(Busy), 32'(0));

        // Load B = 1000_0001, arm, full run held low 40 cycles.
        switches = 8'h81;
        applyStimulus(1, 0, 0);
        #1;
        checkOutput("lit_load_clrld", 32'(ClrA_LdB), 32'(1));
        tick();
        applyStimulus(1, 1, 1);
        tick();
        runAndCheckTiming(1);

        // Release leaves DONE; re-press starts a new clear.
        applyStimulus(1, 1, 1);
        tick();
        #1;
        checkOutput("lit_release_done", 32'(Done), 32'(0));
        checkOutput("lit_release_busy", 32'(Busy), 32'(0));
        applyStimulus(1, 0, 1);
        tick();
        #1;
        checkOutput("lit_repress_clrax", 32'(ClrAX), 32'(1));
        applyStimulus(1, 1, 1);
        repeat (20) tick();

        // ClearA_LoadB pressed mid-run is ignored.
        switches = 8'($urandom);
        applyStimulus(1, 1, 0);
        tick();
        applyStimulus(1, 0, 1);
        tick();
        for (int c = 1; c <= 19; c++) begin
            applyStimulus(1, 0, !(c >= 5 && c <= 9));
            #1;
            if (c >= 5 && c <= 9) checkOutput($sformatf("lit_conflict_c%0d", c), 32'(ClrA_LdB), 32'(0));
            tick();
        end
        #1;
        checkOutput("lit_conflict_done", 32'(Done), 32'(1));
        applyStimulus(1, 1, 1);
        tick();

        // Both buttons low in IDLE: load wins, no start.
        applyStimulus(1, 0, 0);
        #1;
        checkOutput("lit_both_clrld", 32'(ClrA_LdB), 32'(1));
        tick();
        #1;
        checkOutput("lit_both_busy", 32'(Busy), 32'(0));

        // Reset at cycle 9 of a run; Run still low must not restart.
        applyStimulus(1, 0, 1);
        tick();
        for (int c = 1; c <= 8; c++) begin
            applyStimulus(1, 0, 1);
            tick();
        end
        applyStimulus(0, 0, 1);
        tick();
        #1;
        checkOutput("lit_midrst_busy", 32'(Busy), 32'(0));
        checkOutput("lit_midrst_shift", 32'(Shift_En), 32'(0));
        checkOutput("lit_midrst_add", 32'(Add_En), 32'(0));
        checkOutput("lit_midrst_cnt", 32'(Bit_Cnt), 32'(0));
        applyStimulus(1, 0, 1);
        repeat (4) tick();
        #1;
        checkOutput("lit_midrst_hold", 32'(Busy), 32'(0));

        // B = 0: no adds, same shift/done timing.
        switches = 8'h00;
        applyStimulus(1, 1, 0);
        tick();
        applyStimulus(1, 1, 1);
        tick();
        runAndCheckTiming(0);
        applyStimulus(1, 1, 1);
        tick();

        // Random phase against the model.
        for (int i = 0; i < 3000; i++) begin
            bit r, run, clb;
            r   = ($urandom_range(0, 149) != 0);
            run = ($urandom_range(0, 9) == 0) ? !Run : Run;
            clb = ($urandom_range(0, 11) != 0);
            switches = 8'($urandom);
            applyStimulus(r, run, clb);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
